// File: rtl/rs_alu_pkg.sv
// ---------------------------------------------------------------------------
// rs_alu_pkg
// Shared constants for the ALU reservation station: ROB tag width, boolean
// and null literals, ALU opcode codes and the reservation-station entry
// record. Replaces the old defines.v macros.
// ---------------------------------------------------------------------------
package rs_alu_pkg;

    // ROB tag width (RBID)
    localparam int RBID_W = 4;

    // Reservation station geometry defaults
    localparam int RS_SIZE_DEF = 16;
    localparam int RS_IDW_DEF  = 4;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [31:0] NULL32 = 32'h0000_0000;

    // ALU opcode codes
    typedef enum logic [5:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_BEQ   = 6'd11,
        OP_BNE   = 6'd12,
        OP_BLT   = 6'd13,
        OP_BGE   = 6'd14,
        OP_BLTU  = 6'd15,
        OP_BGEU  = 6'd16,
        OP_LUI   = 6'd17,
        OP_AUIPC = 6'd18,
        OP_JAL   = 6'd19,
        OP_JALR  = 6'd20
    } alu_op_e;

    // One reservation-station slot
    typedef struct packed {
        logic              busy;
        logic [5:0]        op;
        logic [31:0]       vj;
        logic [31:0]       vk;
        logic [RBID_W-1:0] qj;
        logic [RBID_W-1:0] qk;
        logic              qj_rdy;
        logic              qk_rdy;
        logic [RBID_W-1:0] rob;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_select.sv
// ---------------------------------------------------------------------------
// rs_select
// Combinational lowest-index priority encoder.
//   req   : request vector, bit i set when slot i qualifies
//   found : at least one request bit set
//   idx   : index of the lowest set request bit (0 when none)
// ---------------------------------------------------------------------------
module rs_select #(
    parameter int N   = 16,
    parameter int IDW = 4
) (
    input  logic [N-1:0]   req,
    output logic           found,
    output logic [IDW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                found = 1'b1;
                idx   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ---------------------------------------------------------------------------
// rs_alu
// Reservation station for the integer ALU. Buffers dispatched micro-ops,
// snoops the ALU and LSB common data buses for pending operand tags and
// issues the lowest-index ready entry to the ALU once per cycle.
//   clk_in / rst_in / rdy_in / clr_in : clock, sync reset, enable, flush
//   dsp_*                              : dispatch port
//   rs_full                            : back-pressure to dispatcher
//   alu_cdb_* / lsb_cdb_*              : result broadcasts
//   alu_flag / alu_val1 / alu_val2 / alu_op / alu_rob : ALU issue port
// ---------------------------------------------------------------------------
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int RS_IDW  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,

    input  logic              dsp_en,
    input  logic [5:0]        dsp_op,
    input  logic [31:0]       dsp_vj,
    input  logic [31:0]       dsp_vk,
    input  logic              dsp_qj_rdy,
    input  logic              dsp_qk_rdy,
    input  logic [RBID_W-1:0] dsp_qj,
    input  logic [RBID_W-1:0] dsp_qk,
    input  logic [RBID_W-1:0] dsp_rob,
    output logic              rs_full,

    input  logic              alu_cdb_en,
    input  logic [RBID_W-1:0] alu_cdb_rob,
    input  logic [31:0]       alu_cdb_val,
    input  logic              lsb_cdb_en,
    input  logic [RBID_W-1:0] lsb_cdb_rob,
    input  logic [31:0]       lsb_cdb_val,

    output logic              alu_flag,
    output logic [31:0]       alu_val1,
    output logic [31:0]       alu_val2,
    output logic [5:0]        alu_op,
    output logic [RBID_W-1:0] alu_rob
);

    rs_entry_t ent     [RS_SIZE];
    rs_entry_t ent_nxt [RS_SIZE];

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_IDW:0]    busy_cnt;

    logic               rdy_found;
    logic [RS_IDW-1:0]  rdy_idx;
    logic               free_found;
    logic [RS_IDW-1:0]  free_idx;

    logic               dj_rdy;
    logic [31:0]        dj_val;
    logic               dk_rdy;
    logic [31:0]        dk_val;

    // Occupancy and readiness vectors
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        busy_cnt  = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && ent[i].qj_rdy && ent[i].qk_rdy;
            busy_cnt     = busy_cnt + (RS_IDW+1)'(ent[i].busy);
        end
    end

    // One slot of margin covers a dispatch already launched this cycle
    assign rs_full = (int'(busy_cnt) >= RS_SIZE - 1);

    rs_select #(.N(RS_SIZE), .IDW(RS_IDW)) u_ready_sel (
        .req   (ready_vec),
        .found (rdy_found),
        .idx   (rdy_idx)
    );

    // The slot being issued this edge is reusable by the dispatch on the same edge
    always_comb begin
        free_vec = ~busy_vec;
        if (rdy_found) begin
            free_vec[rdy_idx] = 1'b1;
        end
    end

    rs_select #(.N(RS_SIZE), .IDW(RS_IDW)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    // Dispatch-time bypass; ALU CDB takes priority over LSB CDB
    always_comb begin
        dj_rdy = dsp_qj_rdy;
        dj_val = dsp_vj;
        if (!dsp_qj_rdy) begin
            if (alu_cdb_en && alu_cdb_rob == dsp_qj) begin
                dj_rdy = TRUE;
                dj_val = alu_cdb_val;
            end else if (lsb_cdb_en && lsb_cdb_rob == dsp_qj) begin
                dj_rdy = TRUE;
                dj_val = lsb_cdb_val;
            end
        end
        dk_rdy = dsp_qk_rdy;
        dk_val = dsp_vk;
        if (!dsp_qk_rdy) begin
            if (alu_cdb_en && alu_cdb_rob == dsp_qk) begin
                dk_rdy = TRUE;
                dk_val = alu_cdb_val;
            end else if (lsb_cdb_en && lsb_cdb_rob == dsp_qk) begin
                dk_rdy = TRUE;
                dk_val = lsb_cdb_val;
            end
        end
    end

    // Next entry state: snoop, then issue clear, then dispatch (dispatch wins the slot)
    always_comb begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].busy) begin
                if (!ent[i].qj_rdy) begin
                    if (alu_cdb_en && alu_cdb_rob == ent[i].qj) begin
                        ent_nxt[i].vj     = alu_cdb_val;
                        ent_nxt[i].qj_rdy = TRUE;
                    end else if (lsb_cdb_en && lsb_cdb_rob == ent[i].qj) begin
                        ent_nxt[i].vj     = lsb_cdb_val;
                        ent_nxt[i].qj_rdy = TRUE;
                    end
                end
                if (!ent[i].qk_rdy) begin
                    if (alu_cdb_en && alu_cdb_rob == ent[i].qk) begin
                        ent_nxt[i].vk     = alu_cdb_val;
                        ent_nxt[i].qk_rdy = TRUE;
                    end else if (lsb_cdb_en && lsb_cdb_rob == ent[i].qk) begin
                        ent_nxt[i].vk     = lsb_cdb_val;
                        ent_nxt[i].qk_rdy = TRUE;
                    end
                end
            end
        end
        if (rdy_found) begin
            ent_nxt[rdy_idx].busy = FALSE;
        end
        if (dsp_en && free_found) begin
            ent_nxt[free_idx].busy   = TRUE;
            ent_nxt[free_idx].op     = dsp_op;
            ent_nxt[free_idx].vj     = dj_val;
            ent_nxt[free_idx].vk     = dk_val;
            ent_nxt[free_idx].qj     = dsp_qj;
            ent_nxt[free_idx].qk     = dsp_qk;
            ent_nxt[free_idx].qj_rdy = dj_rdy;
            ent_nxt[free_idx].qk_rdy = dk_rdy;
            ent_nxt[free_idx].rob    = dsp_rob;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && clr_in)) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            alu_flag <= FALSE;
            alu_val1 <= NULL32;
            alu_val2 <= NULL32;
            alu_op   <= '0;
            alu_rob  <= '0;
        end else if (rdy_in) begin
            ent <= ent_nxt;
            if (rdy_found) begin
                alu_flag <= TRUE;
                alu_val1 <= ent[rdy_idx].vj;
                alu_val2 <= ent[rdy_idx].vk;
                alu_op   <= ent[rdy_idx].op;
                alu_rob  <= ent[rdy_idx].rob;
            end else begin
                alu_flag <= FALSE;
                alu_val1 <= NULL32;
                alu_val2 <= NULL32;
                alu_op   <= '0;
                alu_rob  <= '0;
            end
        end
    end

endmodule

// File: doc/rs_alu.md
# rs_alu

Reservation station for the integer ALU in the out-of-order core. It buffers dispatched arithmetic and branch micro-ops until both operands are valid, snoops the common data buses for pending ROB tags, and issues one ready micro-op per cycle to the combinational ALU. It drives the ALU's input side (`val1`, `val2`, `flag`, `opcode`, `rob_reorder`) and consumes the ALU and LSB broadcasts on the CDB.

## Interface
- `RS_SIZE`, 16: number of entries.
- `RS_IDW`, 4: entry index width, log2(RS_SIZE).
- `clk_in` in 1: clock.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: global enable; low freezes all state.
- `clr_in` in 1: flush on mispredict; synchronous, same effect as reset.
- `dsp_en` in 1: dispatch valid this cycle.
- `dsp_op` in 6: opcode, encoded with `defines.v` values.
- `dsp_vj`, `dsp_vk` in 32: operand values.
- `dsp_qj_rdy`, `dsp_qk_rdy` in 1: operand already valid.
- `dsp_qj`, `dsp_qk` in `RBID`: producing ROB tag when not ready.
- `dsp_rob` in `RBID`: destination ROB tag.
- `rs_full` out 1: dispatcher must not assert `dsp_en` next cycle.
- `alu_cdb_en`, `lsb_cdb_en` in 1: broadcast valid.
- `alu_cdb_rob`, `lsb_cdb_rob` in `RBID`: broadcast tag.
- `alu_cdb_val`, `lsb_cdb_val` in 32: broadcast value.
- `alu_flag` out 1: issue valid, to ALU `flag`.
- `alu_val1`, `alu_val2` out 32: operands.
- `alu_op` out 6: opcode.
- `alu_rob` out `RBID`: ROB tag.

## Operation
- Entry state: busy, op, vj, vk, qj, qk, qj_rdy, qk_rdy, rob. An entry is ready when busy && qj_rdy && qk_rdy.
- Dispatch: on an edge with `dsp_en`, write the lowest-index free entry. A not-ready operand whose tag matches a CDB valid in the same cycle is captured as ready with the CDB value (bypass). ALU CDB has priority over LSB CDB if both match; that case is legal only for identical values.
- Snoop: every edge, each busy entry with a pending qj or qk matching an enabled CDB tag loads the value and sets the ready bit. Both operands may resolve on the same edge.
- Issue: every edge, select the lowest-index ready entry from pre-edge state. Load `alu_*` and set `alu_flag`=`True`. Clear that entry's busy bit. If no entry is ready, `alu_flag`=`False` and the other outputs are zero (`null32`, 0).
- Issue and dispatch may target the same index on one edge. Dispatch wins the slot; the issue read uses the pre-edge contents.
- `rs_full` is a combinational output: 1 when busy count >= RS_SIZE-1. This margin covers a dispatch already in flight.
- `rst_in` or `clr_in`: all busy bits cleared and all outputs zero. Any dispatch or snoop on that edge is dropped. `clr_in` is ignored while `rdy_in`=0.
- `rdy_in`=0: all registers hold, including `alu_*`. The ALU keeps presenting the same result.

## Timing
- Reset values: `alu_flag`=0, `alu_val1`=`alu_val2`=0, `alu_op`=0, `alu_rob`=0, `rs_full`=0.
- Minimum latency: dispatch with both operands ready at edge k gives issue at edge k+1. `alu_flag` is high during cycle k+1..k+2, and the ALU CDB result appears in that same cycle.
- An operand woken at edge k is eligible for issue at edge k+1.
- Back-to-back dependent ops: producer issues at edge k. Its CDB is valid in cycle k..k+1 and the consumer wakes at edge k+1. The consumer issues at edge k+2, giving one bubble.
- Throughput is one issue per cycle. `alu_flag` stays high for exactly one cycle per issued op.

## Structure
- `defines.v` holds the shared constants: opcode codes, `RBID`, `True`/`False`, `null32`. RS_SIZE-related widths go there as well.
- One sub-module, `rs_select`: a combinational lowest-index priority encoder. It is instantiated twice, once for the free-slot pick and once for the ready-slot pick. Each instance outputs a found flag and an `RS_IDW`-bit index.

## Test plan
- Single op: reset, then dispatch ADD with vj=5, vk=7, both ready, rob=3 at edge 1. At edge 2 expect `alu_flag`=1, `alu_val1`=5, `alu_val2`=7, `alu_rob`=3. At edge 3 expect `alu_flag`=0.
- Wakeup: dispatch SUB with qj=2 not ready, vk=1. Broadcast LSB CDB rob=2 val=10 two cycles later. Expect issue on the following edge with `alu_val1`=10, `alu_val2`=1.
- Dispatch bypass: dispatch with qj=6 while `alu_cdb_en`=1, rob=6, val=0xFFFFFFFF in the same cycle. Expect issue on the next edge with `alu_val1`=0xFFFFFFFF.
- Full and order: fill 15 entries, all blocked on tag 9. Expect `rs_full`=1. Broadcast tag 9, then expect 15 issues on consecutive edges in index order 0..14.
- Flush: 4 entries busy, assert `clr_in` with a simultaneous dispatch. Next cycle expect `alu_flag`=0, `rs_full`=0, and no later issues.
- Stall: assert `rdy_in`=0 for 3 cycles while `alu_flag`=1. Expect outputs unchanged, and no wakeup from CDBs pulsed during the stall.
